// File: rtl/div_pkg.sv
// Shared types and sizing for the iterative RV32M divide/remainder unit.
package div_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        CALC,
        FIX
    } div_state_e;

endpackage

// File: rtl/div_abs_neg.sv
// Conditional two's-complement: operand magnitude on the way in, result sign on the way out.
module div_abs_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] in,
    input  logic         neg_en,
    output logic [W-1:0] out
);

    assign out = neg_en ? (~in + {{(W-1){1'b0}}, 1'b1}) : in;

endmodule

// File: rtl/div_rem_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional early-out path for trivial operands is enabled by defining DIV_FASTPATH_EN.
module div_rem_unit
    import div_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [1:0]      i_div_op,
    input  logic [XLEN-1:0] i_operand_a,
    input  logic [XLEN-1:0] i_operand_b,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_div_data
);

    div_state_e       state, state_nxt;
    div_op_e          op;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  a_abs, b_abs, a_q, b_q, quo, rem, res_q;
    logic [XLEN-1:0]  quo_fix, rem_fix, result;
    logic [XLEN:0]    rem_sh, diff;
    logic             is_signed, accept, borrow;
    logic             sign_a, neg_q, is_rem;

    assign op        = div_op_e'(i_div_op);
    assign is_signed = (op == DIV) || (op == REM);
    assign accept    = (state == IDLE) && i_start && !i_flush;

    div_abs_neg #(.W(XLEN)) u_abs_a (.in(i_operand_a), .neg_en(is_signed & i_operand_a[XLEN-1]), .out(a_abs));
    div_abs_neg #(.W(XLEN)) u_abs_b (.in(i_operand_b), .neg_en(is_signed & i_operand_b[XLEN-1]), .out(b_abs));
    div_abs_neg #(.W(XLEN)) u_fix_q (.in(quo), .neg_en(neg_q),  .out(quo_fix));
    div_abs_neg #(.W(XLEN)) u_fix_r (.in(rem), .neg_en(sign_a), .out(rem_fix));

    // Borrow out of the XLEN+1-bit trial subtract lands in the top bit.
    assign rem_sh = {rem, quo[XLEN-1]};
    assign diff   = rem_sh - {1'b0, b_q};
    assign borrow = diff[XLEN];

`ifdef DIV_FASTPATH_EN
    logic            b_zero, b_one, fast_hit;
    logic [XLEN-1:0] fast_quo, fast_rem;

    // |b|==1 covers the signed-overflow case: quotient is |a|, remainder 0.
    assign b_zero   = (b_q == '0);
    assign b_one    = (b_q == XLEN'(1));
    assign fast_hit = b_zero || b_one || (a_q < b_q);
    assign fast_quo = b_zero ? '1 : (b_one ? a_q : '0);
    assign fast_rem = b_one ? '0 : a_q;
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (i_start) state_nxt = INIT;
`ifdef DIV_FASTPATH_EN
            INIT: state_nxt = fast_hit ? FIX : CALC;
`else
            INIT: state_nxt = CALC;
`endif
            CALC: if (cnt == CNT_W'(1)) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (i_flush) state_nxt = IDLE;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            a_q    <= '0;
            b_q    <= '0;
            quo    <= '0;
            rem    <= '0;
            res_q  <= '0;
            cnt    <= '0;
            sign_a <= 1'b0;
            neg_q  <= 1'b0;
            is_rem <= 1'b0;
        end else begin
            if (accept) begin
                a_q    <= a_abs;
                b_q    <= b_abs;
                sign_a <= is_signed & i_operand_a[XLEN-1];
                // A zero divisor must leave the all-ones quotient unsigned.
                neg_q  <= is_signed & (i_operand_a[XLEN-1] ^ i_operand_b[XLEN-1]) & (|i_operand_b);
                is_rem <= i_div_op[1];
            end
            if (state == INIT) begin
                cnt <= CNT_W'(XLEN);
`ifdef DIV_FASTPATH_EN
                quo <= fast_hit ? fast_quo : a_q;
                rem <= fast_hit ? fast_rem : '0;
`else
                quo <= a_q;
                rem <= '0;
`endif
            end
            if (state == CALC) begin
                rem <= borrow ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
                quo <= {quo[XLEN-2:0], ~borrow};
                cnt <= cnt - CNT_W'(1);
            end
            if (o_valid) res_q <= result;
        end
    end

    assign result     = is_rem ? rem_fix : quo_fix;
    assign o_busy     = (state != IDLE);
    assign o_valid    = (state == FIX) && !i_flush;
    assign o_div_data = o_valid ? result : res_q;

endmodule

// File: tb/tb_div_rem_unit.sv
// Directed and model-checked bench for div_rem_unit; latency is counted in cycles after the accepting edge.
module tb_div_rem_unit;
    import div_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [1:0]  i_div_op;
    logic [31:0] i_operand_a;
    logic [31:0] i_operand_b;
    logic        i_flush;
    logic        o_busy;
    logic        o_valid;
    logic [31:0] o_div_data;

    int n_chk  = 0;
    int n_fail = 0;

    div_rem_unit dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_div_op    (i_div_op),
        .i_operand_a (i_operand_a),
        .i_operand_b (i_operand_b),
        .i_flush     (i_flush),
        .o_busy      (o_busy),
        .o_valid     (o_valid),
        .o_div_data  (o_div_data)
    );

    always #5 i_clk = ~i_clk;

    // Leaves the bench at the falling edge of the first cycle after acceptance.
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge i_clk);
        i_div_op    = op;
        i_operand_a = a;
        i_operand_b = b;
        i_start     = 1'b1;
        @(negedge i_clk);
        i_start     = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] data, output int lat, output int busy_cnt);
        start_op(op, a, b);
        lat      = 1;
        busy_cnt = 0;
        while (!o_valid && lat < 100) begin
            if (o_busy) busy_cnt++;
            @(negedge i_clk);
            lat++;
        end
        data = o_div_data;
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            2'b00:   model = (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
            2'b01:   model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   model = (b == 0) ? a : (ovf ? 32'h0 : 32'($signed(a) % $signed(b)));
            default: model = (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic test_reset();
        n_chk++; if (o_busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", o_busy); end
        n_chk++; if (o_valid !== 1'b0)     begin n_fail++; $display("FAIL reset_valid got %b want 0", o_valid); end
        n_chk++; if (o_div_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", o_div_data); end
    endtask

    task automatic test_basic();
        logic [31:0] d; int lat, bc;
        run_op(DIV, 32'd100, 32'd7, d, lat, bc);
        n_chk++; if (d !== 32'd14)  begin n_fail++; $display("FAIL div_100_7 got %h want %h", d, 32'd14); end
        n_chk++; if (lat !== 34)    begin n_fail++; $display("FAIL div_latency got %0d want 34", lat); end
        n_chk++; if (bc !== 33)     begin n_fail++; $display("FAIL busy_before_valid got %0d want 33", bc); end
        n_chk++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_fix got %b want 1", o_busy); end
        @(negedge i_clk);
        n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL valid_pulse_width got %b want 0", o_valid); end
        n_chk++; if (o_busy !== 1'b0)  begin n_fail++; $display("FAIL busy_after_fix got %b want 0", o_busy); end
        n_chk++; if (o_div_data !== 32'd14) begin n_fail++; $display("FAIL data_hold got %h want %h", o_div_data, 32'd14); end
        run_op(REM, 32'd100, 32'd7, d, lat, bc);
        n_chk++; if (d !== 32'd2)   begin n_fail++; $display("FAIL rem_100_7 got %h want 2", d); end
    endtask

    task automatic test_signed();
        logic [31:0] d; int lat, bc;
        run_op(DIV, 32'hFFFF_FF9C, 32'd7, d, lat, bc);
        n_chk++; if (d !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL div_neg100_7 got %h want fffffff2", d); end
        run_op(REM, 32'hFFFF_FF9C, 32'd7, d, lat, bc);
        n_chk++; if (d !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL rem_neg100_7 got %h want fffffffe", d); end
        run_op(DIVU, 32'hFFFF_FF9C, 32'd7, d, lat, bc);
        n_chk++; if (d !== 32'h2492_4916) begin n_fail++; $display("FAIL divu_big_7 got %h want 24924916", d); end
        run_op(REMU, 32'hFFFF_FF9C, 32'd7, d, lat, bc);
        n_chk++; if (d !== 32'd2)         begin n_fail++; $display("FAIL remu_big_7 got %h want 2", d); end
        run_op(DIV, 32'd100, 32'hFFFF_FFF9, d, lat, bc);
        n_chk++; if (d !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL div_100_neg7 got %h want fffffff2", d); end
        run_op(REM, 32'hFFFF_FF9C, 32'hFFFF_FFF9, d, lat, bc);
        n_chk++; if (d !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL rem_neg_neg got %h want fffffffe", d); end
    endtask

    task automatic test_div_zero();
        logic [31:0] d; int lat, bc;
        run_op(DIVU, 32'd5, 32'd0, d, lat, bc);
        n_chk++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_by0 got %h want ffffffff", d); end
        n_chk++; if (lat !== 34)          begin n_fail++; $display("FAIL by0_latency got %0d want 34", lat); end
        run_op(REMU, 32'd5, 32'd0, d, lat, bc);
        n_chk++; if (d !== 32'd5)         begin n_fail++; $display("FAIL remu_by0 got %h want 5", d); end
        run_op(DIV, 32'hFFFF_FFFB, 32'd0, d, lat, bc);
        n_chk++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_by0 got %h want ffffffff", d); end
        run_op(REM, 32'hFFFF_FFFB, 32'd0, d, lat, bc);
        n_chk++; if (d !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL rem_neg_by0 got %h want fffffffb", d); end
    endtask

    task automatic test_overflow();
        logic [31:0] d; int lat, bc;
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, d, lat, bc);
        n_chk++; if (d !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf got %h want 80000000", d); end
        run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, d, lat, bc);
        n_chk++; if (d !== 32'h0)         begin n_fail++; $display("FAIL rem_ovf got %h want 0", d); end
    endtask

    task automatic test_flush();
        logic [31:0] d; int lat, bc;
        run_op(DIVU, 32'd5, 32'd0, d, lat, bc);
        start_op(DIV, 32'd100, 32'd7);
        repeat (9) @(negedge i_clk);
        i_flush = 1'b1;
        n_chk++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", o_valid); end
        @(negedge i_clk);
        i_flush = 1'b0;
        n_chk++; if (o_busy !== 1'b0)  begin n_fail++; $display("FAIL flush_busy got %b want 0", o_busy); end
        n_chk++; if (o_div_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL flush_data got %h want ffffffff", o_div_data); end
        run_op(DIV, 32'd100, 32'd7, d, lat, bc);
        n_chk++; if (d !== 32'd14) begin n_fail++; $display("FAIL after_flush_data got %h want %h", d, 32'd14); end
        n_chk++; if (lat !== 34)   begin n_fail++; $display("FAIL after_flush_latency got %0d want 34", lat); end
    endtask

    task automatic test_busy_ignore();
        int lat;
        start_op(DIV, 32'd100, 32'd7);
        lat = 1;
        while (!o_valid && lat < 100) begin
            if (lat == 5 || lat == 20) begin
                i_start = 1'b1; i_div_op = REMU; i_operand_a = 32'd9; i_operand_b = 32'd2;
            end else begin
                i_start = 1'b0;
            end
            @(negedge i_clk);
            lat++;
        end
        i_start = 1'b0;
        n_chk++; if (o_div_data !== 32'd14) begin n_fail++; $display("FAIL busy_ignore_data got %h want %h", o_div_data, 32'd14); end
        n_chk++; if (lat !== 34)            begin n_fail++; $display("FAIL busy_ignore_latency got %0d want 34", lat); end
        @(negedge i_clk);
        n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL busy_ignore_queued got %b want 0", o_busy); end
    endtask

    task automatic test_fix_start();
        logic [31:0] d; int lat, bc;
        run_op(REM, 32'd100, 32'd7, d, lat, bc);
        i_start = 1'b1; i_div_op = DIVU; i_operand_a = 32'd9; i_operand_b = 32'd2;
        @(negedge i_clk);
        n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL fix_start_taken got %b want 0", o_busy); end
        @(negedge i_clk);
        i_start = 1'b0;
        n_chk++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL idle_start_taken got %b want 1", o_busy); end
        lat = 1;
        while (!o_valid && lat < 100) begin
            @(negedge i_clk);
            lat++;
        end
        n_chk++; if (o_div_data !== 32'd4) begin n_fail++; $display("FAIL fix_start_result got %h want 4", o_div_data); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; int lat, bc;
        start_op(DIV, 32'd100, 32'd7);
        repeat (14) @(negedge i_clk);
        #2 i_reset = 1'b0;
        #1;
        n_chk++; if (o_busy !== 1'b0)      begin n_fail++; $display("FAIL midreset_busy got %b want 0", o_busy); end
        n_chk++; if (o_valid !== 1'b0)     begin n_fail++; $display("FAIL midreset_valid got %b want 0", o_valid); end
        n_chk++; if (o_div_data !== 32'h0) begin n_fail++; $display("FAIL midreset_data got %h want 0", o_div_data); end
        @(negedge i_clk);
        i_reset = 1'b1;
        run_op(DIVU, 32'd9, 32'd2, d, lat, bc);
        n_chk++; if (d !== 32'd4) begin n_fail++; $display("FAIL post_reset_op got %h want 4", d); end
    endtask

    task automatic test_small_dividend();
        logic [31:0] d; int lat, bc;
        run_op(DIVU, 32'd3, 32'd9, d, lat, bc);
        n_chk++; if (d !== 32'd0) begin n_fail++; $display("FAIL divu_3_9 got %h want 0", d); end
`ifdef DIV_FASTPATH_EN
        n_chk++; if (lat > 3)     begin n_fail++; $display("FAIL fast_latency got %0d want <=3", lat); end
`else
        n_chk++; if (lat !== 34)  begin n_fail++; $display("FAIL small_latency got %0d want 34", lat); end
`endif
        run_op(REMU, 32'd3, 32'd9, d, lat, bc);
        n_chk++; if (d !== 32'd3) begin n_fail++; $display("FAIL remu_3_9 got %h want 3", d); end
    endtask

    task automatic test_random();
        logic [31:0] d, a, b, exp; logic [1:0] op; int lat, bc;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 20));
                default: b = 32'($urandom);
            endcase
            exp = model(op, a, b);
            run_op(op, a, b, d, lat, bc);
            n_chk++;
            if (d !== exp) begin
                n_fail++;
                $display("FAIL random op=%0d a=%h b=%h got %h want %h", op, a, b, d, exp);
            end
        end
    endtask

    initial begin
        i_reset = 1'b0; i_start = 1'b0; i_flush = 1'b0;
        i_div_op = 2'b00; i_operand_a = '0; i_operand_b = '0;
        repeat (2) @(negedge i_clk);
        test_reset();
        i_reset = 1'b1;
        test_basic();
        test_signed();
        test_div_zero();
        test_overflow();
        test_flush();
        test_busy_ignore();
        test_fix_start();
        test_reset_mid();
        test_small_dividend();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
